// File: rtl/rapid_lsu_pkg.sv
// rapid_lsu_pkg
// Shared types for the rapid MEM-stage load/store unit: FSM state, error codes,
// cache command enums, funct3 width/sign codes and the latched request record.
package rapid_lsu_pkg;

  typedef enum logic [1:0] {
    MEM_WAIT  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2,
    MEM_DRAIN = 2'd3
  } MEM_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_ILLEGAL  = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } mem_err_t;

  typedef enum logic {
    CACHE_READ  = 1'b0,
    CACHE_WRITE = 1'b1
  } cache_rw_t;

  typedef enum logic [1:0] {
    QUARTER_WORD = 2'd0,
    HALF_WORD    = 2'd1,
    WORD         = 2'd2
  } cache_operation;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef struct packed {
    logic       store;
    logic [2:0] funct3;
    logic [4:0] rd;
  } lsu_req_s;

endpackage

// File: rtl/rapid_lsu_if.sv
// rapid_lsu_if
// Bundles the EX->MEM request handshake, the response pulse and the data-cache
// command/ack bus of the load/store unit.
//   slave  : the LSU (accepts requests, drives responses and cache commands)
//   master : the core/cache side (drives requests, flush, ack and read data)
interface rapid_lsu_if
  import rapid_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  localparam int NB = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;
  logic              flush;
  logic              rsp_valid;
  logic [4:0]        rsp_rd;
  logic [XLEN-1:0]   rsp_data;
  mem_err_t          rsp_err;
  logic              cache_req;
  cache_rw_t         cache_rw;
  cache_operation    cache_op;
  logic [ADDR_W-1:0] cache_addr;
  logic [NB-1:0]     cache_be;
  logic [XLEN-1:0]   cache_wdata;
  logic              cache_ack;
  logic [XLEN-1:0]   cache_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, flush,
           cache_ack, cache_rdata,
    output req_ready, rsp_valid, rsp_rd, rsp_data, rsp_err,
           cache_req, cache_rw, cache_op, cache_addr, cache_be, cache_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, req_rd, flush,
           cache_ack, cache_rdata,
    input  req_ready, rsp_valid, rsp_rd, rsp_data, rsp_err,
           cache_req, cache_rw, cache_op, cache_addr, cache_be, cache_wdata
  );
endinterface

// File: rtl/rapid_lsu_align.sv
// rapid_lsu_align
// Combinational lane logic: from funct3, store flag and byte offset derives the
// legality/alignment error, byte enables, lane-replicated store data, cache
// access size and the shifted, sign/zero-extended load value.
//   funct3, store, ofs, wdata, rdata -> be, wdata_rep, ldata, err, op
module rapid_lsu_align
  import rapid_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB  = XLEN / 8,
  localparam int OFS = $clog2(NB)
) (
  input  logic [2:0]      funct3,
  input  logic            store,
  input  logic [OFS-1:0]  ofs,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [NB-1:0]   be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] ldata,
  output mem_err_t        err,
  output cache_operation  op
);
  logic [1:0]      sz;
  logic            legal;
  logic [OFS-1:0]  amask;
  logic [NB-1:0]   bmask;
  logic [XLEN-1:0] sh;

  assign sz = funct3[1:0];

  always_comb begin
    legal = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !store;
      F3_D:             legal = (XLEN == 64);
      F3_WU:            legal = (XLEN == 64) && !store;
      default:          legal = 1'b0;
    endcase

    // Offset bits that must be zero for a naturally aligned access.
    case (sz)
      2'd0:    begin amask = '0;        bmask = NB'(1);   op = QUARTER_WORD; end
      2'd1:    begin amask = OFS'(1);   bmask = NB'(3);   op = HALF_WORD;    end
      2'd2:    begin amask = OFS'(3);   bmask = NB'(15);  op = WORD;         end
      default: begin amask = OFS'(7);   bmask = NB'(255); op = WORD;         end
    endcase

    if (!legal)                err = ERR_ILLEGAL;
    else if ((ofs & amask) != '0) err = ERR_MISALIGN;
    else                       err = ERR_NONE;

    be = bmask << ofs;

    case (sz)
      2'd0:    wdata_rep = {NB{wdata[7:0]}};
      2'd1:    wdata_rep = {(NB/2){wdata[15:0]}};
      2'd2:    wdata_rep = {(NB/4){wdata[31:0]}};
      default: wdata_rep = wdata;
    endcase

    sh = rdata >> {ofs, 3'b000};
    case (sz)
      2'd0:    ldata = funct3[2] ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
      2'd1:    ldata = funct3[2] ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
      2'd2:    ldata = funct3[2] ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
      default: ldata = sh;
    endcase
  end
endmodule

// File: rtl/rapid_lsu.sv
// rapid_lsu
// MEM-stage load/store unit: accepts one request at a time, issues a single
// cache access (or an immediate error response), waits for ack with a timeout
// and returns a one-cycle response pulse. Flush squashes the transaction but
// lets an issued cache access drain.
//   clk, rst_n : clock, async active-low reset
//   bus        : rapid_lsu_if slave (request, response and cache buses)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// MEM_WAIT  | idle, req_ready=1; error responses are issued from here
// MEM_READ  | load access outstanding, cache_req held until ack/timeout
// MEM_WRITE | store access outstanding, cache_req held until ack/timeout
// MEM_DRAIN | flushed access still outstanding; ends silently on ack/timeout
module rapid_lsu
  import rapid_lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst_n,
  rapid_lsu_if.slave bus
);
  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT - 1);

  MEM_state_t        state;
  lsu_req_s          req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [15:0]       timer;
  logic              cache_req_q, req_ready_q, rsp_valid_q;
  logic [4:0]        rsp_rd_q;
  logic [XLEN-1:0]   rsp_data_q;
  mem_err_t          rsp_err_q;

  logic            in_wait, accept;
  logic [2:0]      a_funct3;
  logic            a_store;
  logic [OFS-1:0]  a_ofs;
  logic [XLEN-1:0] a_wdata;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] wdata_rep, ldata;
  mem_err_t        err;
  cache_operation  op;
  logic [4:0]      rsp_rd;

  // While idle the lane logic classifies the incoming request; once an access
  // is issued it works from the latched copy so the cache sees stable values.
  assign in_wait  = (state == MEM_WAIT);
  assign a_funct3 = in_wait ? bus.req_funct3 : req_q.funct3;
  assign a_store  = in_wait ? bus.req_store : req_q.store;
  assign a_ofs    = in_wait ? bus.req_addr[OFS-1:0] : addr_q[OFS-1:0];
  assign a_wdata  = in_wait ? bus.req_wdata : wdata_q;

  rapid_lsu_align #(.XLEN(XLEN)) u_align (
    .funct3    (a_funct3),
    .store     (a_store),
    .ofs       (a_ofs),
    .wdata     (a_wdata),
    .rdata     (bus.cache_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .ldata     (ldata),
    .err       (err),
    .op        (op)
  );

  // A flush in the accept cycle squashes the request outright.
  assign accept = bus.req_valid && req_ready_q && !bus.flush;
  assign rsp_rd = req_q.store ? 5'd0 : req_q.rd;

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rd      = rsp_rd_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.cache_req   = cache_req_q;
  assign bus.cache_rw    = req_q.store ? CACHE_WRITE : CACHE_READ;
  assign bus.cache_op    = op;
  assign bus.cache_addr  = {addr_q[ADDR_W-1:OFS], {OFS{1'b0}}};
  assign bus.cache_be    = cache_req_q ? be : '0;
  assign bus.cache_wdata = wdata_rep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= MEM_WAIT;
      req_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      timer       <= '0;
      cache_req_q <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= ERR_NONE;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= ERR_NONE;
      case (state)
        MEM_WAIT: begin
          if (accept) begin
            req_q   <= '{store: bus.req_store, funct3: bus.req_funct3, rd: bus.req_rd};
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            if (err != ERR_NONE) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= err;
              rsp_rd_q    <= bus.req_store ? 5'd0 : bus.req_rd;
            end else begin
              state       <= bus.req_store ? MEM_WRITE : MEM_READ;
              cache_req_q <= 1'b1;
              req_ready_q <= 1'b0;
              timer       <= TMO_LOAD;
            end
          end
        end
        MEM_READ, MEM_WRITE: begin
          // Ack is tested first so an ack on the limit cycle still completes.
          if (bus.cache_ack || timer == '0) begin
            state       <= MEM_WAIT;
            cache_req_q <= 1'b0;
            req_ready_q <= 1'b1;
            if (!bus.flush) begin
              rsp_valid_q <= 1'b1;
              rsp_rd_q    <= rsp_rd;
              rsp_err_q   <= bus.cache_ack ? ERR_NONE : ERR_TIMEOUT;
              rsp_data_q  <= (bus.cache_ack && !req_q.store) ? ldata : '0;
            end
          end else begin
            timer <= timer - 16'd1;
            if (bus.flush) state <= MEM_DRAIN;
          end
        end
        MEM_DRAIN: begin
          if (bus.cache_ack || timer == '0) begin
            state       <= MEM_WAIT;
            cache_req_q <= 1'b0;
            req_ready_q <= 1'b1;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        default: state <= MEM_WAIT;
      endcase
    end
  end
endmodule
